// File: rtl/fpconv_serial.sv
// Iterative fixed-to-float converter: a two's-complement sample is normalised
// one left shift per cycle, rounded to nearest, and returned as (-1)^S * F * 2^E.
module fpconv_serial #(
  parameter int FW = 4,
  parameter int EW = 3,
  localparam int DW = FW + (1 << EW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          S,
  output logic [EW-1:0] E,
  output logic [FW-1:0] F,
  output logic          ovf
);

  localparam int MW = DW - 1;
  localparam logic [EW-1:0] EMAX = '1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic                 sign;
  logic [MW-1:0]        sh;
  logic [EW-1:0]        exp;
  logic                 sat;
  logic                 accept;
  logic                 norm_done;
  logic signed [DW-1:0] d_s;
  logic [DW-1:0]        mag;
  logic [EW+FW:0]       rounded;

  // Returns {ovf, E, F}; a carry out of an all-ones fraction bumps the exponent
  // unless the exponent is already at its ceiling, which saturates instead.
  function automatic logic [EW+FW:0] round_nearest(input logic [MW-1:0] m,
                                                    input logic [EW-1:0] e,
                                                    input logic          s);
    logic [FW-1:0] frac;
    logic          rbit;
    frac = m[MW-1 -: FW];
    rbit = m[MW-FW-1];
    if (s || (rbit && frac == '1 && e == EMAX))
      return {1'b1, EMAX, {FW{1'b1}}};
    else if (!rbit)
      return {1'b0, e, frac};
    else if (frac != '1)
      return {1'b0, e, frac + FW'(1)};
    else
      return {1'b0, e + EW'(1), FW'(1) << (FW - 1)};
  endfunction

  assign d_s       = d;
  assign mag       = (d_s < 0) ? -d_s : d_s;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign norm_done = (exp == '0) | sh[MW-1];
  assign rounded   = round_nearest(sh, exp, sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = ROUND;
      ROUND:                  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Capture / normalise: only the most negative sample overflows MW bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign <= d[DW-1];
      sh   <= mag[MW] ? '1 : mag[MW-1:0];
      exp  <= EMAX;
      sat  <= mag[MW];
    end else if (state == NORM && !norm_done) begin
      sh  <= sh << 1;
      exp <= exp - EW'(1);
    end
  end

  // Round stage: result registers hold while DONE waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S   <= 1'b0;
      E   <= '0;
      F   <= '0;
      ovf <= 1'b0;
    end else if (state == ROUND) begin
      S          <= sign;
      {ovf, E, F} <= rounded;
    end
  end

endmodule
